// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-latch inputs, register-file write port, status and trace signals of the write-back stage.
interface wb_stage_if #(
    parameter int DBITS       = 32,
    parameter int INSTBITS    = 32,
    parameter int REGNOBITS   = 5,
    parameter int TRACE_DEPTH = 8
);
    logic                           mem_valid;
    logic [INSTBITS-1:0]            mem_inst;
    logic [DBITS-1:0]               mem_pc;
    logic [DBITS-1:0]               mem_inst_count;
    logic                           mem_wr_reg;
    logic [REGNOBITS-1:0]           mem_wr_idx;
    logic [DBITS-1:0]               mem_result;
    logic                           wb_wr_en;
    logic [REGNOBITS-1:0]           wb_wr_idx;
    logic [DBITS-1:0]               wb_wr_val;
    logic [DBITS-1:0]               retired_cnt;
    logic [DBITS-1:0]               cycle_cnt;
    logic                           halted;
    logic                           seq_err;
    logic [DBITS-1:0]               err_pc;
    logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx;
    logic [DBITS-1:0]               trace_rd_pc;

    modport master (
        output mem_valid, mem_inst, mem_pc, mem_inst_count, mem_wr_reg, mem_wr_idx, mem_result, trace_rd_idx,
        input  wb_wr_en, wb_wr_idx, wb_wr_val, retired_cnt, cycle_cnt, halted, seq_err, err_pc, trace_rd_pc
    );
    modport slave (
        input  mem_valid, mem_inst, mem_pc, mem_inst_count, mem_wr_reg, mem_wr_idx, mem_result, trace_rd_idx,
        output wb_wr_en, wb_wr_idx, wb_wr_val, retired_cnt, cycle_cnt, halted, seq_err, err_pc, trace_rd_pc
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage -- register-file write port, in-order retirement counters, halt detection, order-error capture.
// Optional retired-PC trace ring enabled by defining WB_TRACE_EN.
module wb_stage #(
    parameter int                  DBITS       = 32,
    parameter int                  INSTBITS    = 32,
    parameter int                  REGNOBITS   = 5,
    parameter logic [INSTBITS-1:0] HALT_INST   = 32'h00000073,
    parameter int                  TRACE_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    wb_stage_if.slave  bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t           r_state, w_state_nxt;
    logic [DBITS-1:0] r_retired, r_cycle, r_expect, r_err_pc;
    logic             r_seq_err;
    logic             w_retire;

    // reset gating keeps the reset-cycle input from reaching decode
    assign w_retire = bus.mem_valid && r_state == RUN && !reset;

    always_comb begin
        w_state_nxt = r_state;
        if (w_retire && bus.mem_inst == HALT_INST) w_state_nxt = HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_retired <= '0;
            r_cycle   <= '0;
            r_expect  <= '0;
            r_seq_err <= 1'b0;
            r_err_pc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cycle <= r_cycle + DBITS'(1);
            if (w_retire) begin
                r_retired <= r_retired + DBITS'(1);
                r_expect  <= bus.mem_inst_count + DBITS'(1);
                if (bus.mem_inst_count != r_expect && !r_seq_err) begin
                    r_seq_err <= 1'b1;
                    r_err_pc  <= bus.mem_pc;
                end
            end
        end
    end

    assign bus.wb_wr_en    = w_retire && bus.mem_wr_reg && bus.mem_wr_idx != '0;
    assign bus.wb_wr_idx   = bus.mem_wr_idx;
    assign bus.wb_wr_val   = bus.mem_result;
    assign bus.retired_cnt = r_retired;
    assign bus.cycle_cnt   = r_cycle;
    assign bus.halted      = r_state == HALTED;
    assign bus.seq_err     = r_seq_err;
    assign bus.err_pc      = r_err_pc;

`ifdef WB_TRACE_EN
    localparam int IDXW = $clog2(TRACE_DEPTH);

    logic [DBITS-1:0] r_ring [TRACE_DEPTH];
    logic [IDXW-1:0]  r_wr_ptr, w_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TRACE_DEPTH; k++) r_ring[k] <= '0;
            r_wr_ptr <= '0;
        end else if (w_retire) begin
            r_ring[r_wr_ptr] <= bus.mem_pc;
            r_wr_ptr         <= r_wr_ptr + IDXW'(1);
        end
    end

    // index 0 is the most recently retired PC
    assign w_rd_ptr        = r_wr_ptr - IDXW'(1) - bus.trace_rd_idx;
    assign bus.trace_rd_pc = r_ring[w_rd_ptr];
`else
    logic w_unused_trace;
    assign w_unused_trace  = ^bus.trace_rd_idx;
    assign bus.trace_rd_pc = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed stimulus for wb_stage, checked every cycle against a behavioural model.
module tb_wb_stage;
    localparam int          DBITS = 32;
    localparam int          DEPTH = 8;
    localparam logic [31:0] HALT  = 32'h00000073;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if #(.DBITS(DBITS), .INSTBITS(32), .REGNOBITS(5), .TRACE_DEPTH(DEPTH)) bus ();

    wb_stage #(.DBITS(DBITS), .INSTBITS(32), .REGNOBITS(5), .HALT_INST(HALT), .TRACE_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit started = 0;

    logic [31:0] m_retired, m_cycle, m_expect, m_err_pc;
    bit          m_halted, m_seq_err;
    logic [31:0] m_trace[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] trace_exp(input int idx);
`ifdef WB_TRACE_EN
        return idx < m_trace.size() ? m_trace[idx] : 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    // model of architectural effects of the edge just taken
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_retired = 0; m_cycle = 0; m_expect = 0; m_err_pc = 0;
            m_halted = 0; m_seq_err = 0; m_trace.delete();
            started = 1;
        end else begin
            m_cycle++;
            if (bus.mem_valid && !m_halted) begin
                m_retired++;
                if (bus.mem_inst_count != m_expect && !m_seq_err) begin
                    m_seq_err = 1;
                    m_err_pc  = bus.mem_pc;
                end
                m_expect = bus.mem_inst_count + 1;
                m_trace.push_front(bus.mem_pc);
                if (m_trace.size() > DEPTH) void'(m_trace.pop_back());
                if (bus.mem_inst == HALT) m_halted = 1;
            end
        end
        #1;
    endtask

    task automatic put(input bit v, input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] cnt,
                       input bit wr, input logic [4:0] idx, input logic [31:0] res);
        bus.mem_valid = v; bus.mem_inst = inst; bus.mem_pc = pc; bus.mem_inst_count = cnt;
        bus.mem_wr_reg = wr; bus.mem_wr_idx = idx; bus.mem_result = res;
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        put(0, 32'h13, 0, 0, 0, 0, 0);
        tick();
        reset = 0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("wr_en", bus.wb_wr_en, bus.mem_valid && !m_halted && !reset && bus.mem_wr_reg && bus.mem_wr_idx != 0);
            check("wr_idx", bus.wb_wr_idx, bus.mem_wr_idx);
            check("wr_val", bus.wb_wr_val, bus.mem_result);
            check("retired_cnt", bus.retired_cnt, m_retired);
            check("cycle_cnt", bus.cycle_cnt, m_cycle);
            check("halted", bus.halted, m_halted);
            check("seq_err", bus.seq_err, m_seq_err);
            check("err_pc", bus.err_pc, m_err_pc);
            check("trace_rd_pc", bus.trace_rd_pc, trace_exp(int'(bus.trace_rd_idx)));
        end
    end

    initial begin
        logic [31:0] next_cnt;
        bus.trace_rd_idx = 0;
        do_reset();
        repeat (5) tick();
        check("idle wr_en", bus.wb_wr_en, 0);
        check("idle retired", bus.retired_cnt, 0);
        check("idle cycles", bus.cycle_cnt, 5);
        check("idle halted", bus.halted, 0);

        put(1, 32'h33, 32'h100, 0, 1, 5, 32'h11); check("x5 wr_en", bus.wb_wr_en, 1); tick();
        put(1, 32'h33, 32'h104, 1, 1, 0, 32'h22); check("x0 wr_en", bus.wb_wr_en, 0); tick();
        put(1, 32'h33, 32'h108, 2, 1, 6, 32'h33); check("x6 wr_en", bus.wb_wr_en, 1);
        check("x6 wr_val", bus.wb_wr_val, 32'h33); tick();
        check("write retired", bus.retired_cnt, 3);
        check("write seq_err", bus.seq_err, 0);

        do_reset();
        put(1, 32'h13, 32'h100, 0, 0, 0, 0); tick();
        put(1, 32'h13, 32'h104, 1, 0, 0, 0); tick();
        put(1, 32'h13, 32'h108, 3, 0, 0, 0); tick();
        check("order seq_err", bus.seq_err, 1);
        check("order err_pc", bus.err_pc, 32'h108);
        put(1, 32'h13, 32'h10c, 4, 0, 0, 0); tick();
        check("order err_pc kept", bus.err_pc, 32'h108);

        do_reset();
        put(1, HALT, 32'h200, 0, 0, 0, 0); tick();
        check("halt halted", bus.halted, 1);
        put(1, 32'h33, 32'h204, 1, 1, 7, 32'h77);
        check("halt no write", bus.wb_wr_en, 0);
        tick();
        check("halt retired frozen", bus.retired_cnt, 1);
        do_reset();
        check("post reset halted", bus.halted, 0);
        check("post reset retired", bus.retired_cnt, 0);
        check("post reset cycles", bus.cycle_cnt, 0);

        put(1, 32'h13, 32'h0, 0, 0, 0, 0); tick();
        put(0, 32'h13, 32'h0, 0, 0, 0, 0); tick();
        tick();
        put(1, 32'h13, 32'h4, 1, 0, 0, 0); tick();
        check("bubble retired", bus.retired_cnt, 2);
        check("bubble cycles", bus.cycle_cnt, 4);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1, 32'h13, 32'(4 * i), 32'(i), 0, 0, 0);
            tick();
        end
        put(0, 32'h13, 0, 0, 0, 0, 0);
        bus.trace_rd_idx = 0; #1;
`ifdef WB_TRACE_EN
        check("trace idx0", bus.trace_rd_pc, 32'h24);
        bus.trace_rd_idx = 7; #1;
        check("trace idx7", bus.trace_rd_pc, 32'h8);
`else
        check("trace idx0", bus.trace_rd_pc, 0);
        bus.trace_rd_idx = 7; #1;
        check("trace idx7", bus.trace_rd_pc, 0);
`endif

        do_reset();
        next_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            logic [31:0] cnt;
            v   = $urandom_range(0, 3) != 0;
            cnt = $urandom_range(0, 19) == 0 ? $urandom : next_cnt;
            reset = $urandom_range(0, 99) == 0 || (m_halted && $urandom_range(0, 9) == 0);
            bus.trace_rd_idx = 3'($urandom);
            put(v, $urandom_range(0, 39) == 0 ? HALT : $urandom | 32'h1, $urandom, cnt,
                1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom);
            if (reset) next_cnt = 0;
            else if (v) next_cnt = cnt + 1;
            tick();
        end
        reset = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
